btn_conditioner: RTL and testbench

//   N-channel button/switch input conditioner for the board top level.
//   Per channel: synchronise the raw pad input, debounce it, and emit a

---
 rtl/btn_conditioner.sv | 170 +++++++++++++++++
 tb/tb_btn_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   N-channel button/switch conditioner. Each channel synchronises its raw pad
//   input, debounces it, and produces a clean level, press/release pulses, a
//   long-press hold flag and auto-repeat pulses. Channels are independent.
//
// Ports
//   i_clk      in   1     system clock
//   i_rst      in   1     synchronous reset, active-high
//   i_raw      in   N_CH  asynchronous raw pad inputs, 1 = pressed
//   o_level    out  N_CH  debounced level
//   o_press    out  N_CH  1-cycle pulse on debounced 0->1
//   o_release  out  N_CH  1-cycle pulse on debounced 1->0
//   o_hold     out  N_CH  high from first repeat pulse until release
//   o_repeat   out  N_CH  1-cycle auto-repeat pulse
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int              N_CH            = 5,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 100000,
  parameter int              REPEAT_DELAY    = 5000000,
  parameter int              REPEAT_PERIOD   = 1000000,
  parameter logic [N_CH-1:0] REPEAT_MASK     = {N_CH{1'b1}}
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_raw,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_hold,
  output logic [N_CH-1:0] o_repeat
);

  // Counter widths sized to hold their terminal value, never less than 1 bit.
  localparam int DMAX = DEBOUNCE_CYCLES - 1;
  localparam int DW   = (DMAX > 0) ? $clog2(DMAX + 1) : 1;
  localparam int HMAX = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 1;
  localparam int HW   = (HMAX > 0) ? $clog2(HMAX + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,    // level = 0
    ST_WAIT,    // level = 1, waiting for the first repeat
    ST_REPEAT   // level = 1, hold asserted, periodic repeats
  } hold_state_t;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DW-1:0]          dcnt_q;
    logic                   level_q;
    logic                   press_q;
    logic                   release_q;
    logic                   accept;

    assign s = sync_q[SYNC_STAGES-1];

    // The input has differed from the accepted level for DEBOUNCE_CYCLES
    // consecutive edges (including this one): take the new value now.
    assign accept = (s != level_q) && (dcnt_q == DW'(DMAX));

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its neighbours, exactly like the hardware.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        sync_q    <= '0;
        dcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], i_raw[ch]};
        press_q   <= 1'b0;
        release_q <= 1'b0;
        if (s == level_q) begin
          dcnt_q <= '0;
        end else if (accept) begin
          level_q   <= s;
          dcnt_q    <= '0;
          press_q   <= s;
          release_q <= ~s;
        end else begin
          dcnt_q <= dcnt_q + DW'(1);
        end
      end
    end

    assign o_level[ch]   = level_q;
    assign o_press[ch]   = press_q;
    assign o_release[ch] = release_q;

    if (REPEAT_MASK[ch]) begin : g_rep
      hold_state_t   state_q, state_d;
      logic [HW-1:0] hcnt_q, hcnt_d;
      logic          hold_q, hold_d;
      logic          rep_q, rep_d;
      logic          rise, fall;

      // Hold FSM reacts on the same edge the debounced level changes, so
      // its counter starts together with the o_press cycle.
      assign rise = accept & s;
      assign fall = accept & ~s;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          state_q <= ST_IDLE;
          hcnt_q  <= '0;
          hold_q  <= 1'b0;
          rep_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          hcnt_q  <= hcnt_d;
          hold_q  <= hold_d;
          rep_q   <= rep_d;
        end
      end

      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        hold_d  = hold_q;
        rep_d   = 1'b0;
        if (fall) begin
          // Release wins over a repeat that would fall on the same edge.
          state_d = ST_IDLE;
          hcnt_d  = '0;
          hold_d  = 1'b0;
        end else if (rise) begin
          state_d = ST_WAIT;
          hcnt_d  = '0;
          hold_d  = 1'b0;
        end else begin
          case (state_q)
            ST_WAIT: begin
              if (hcnt_q == HW'(REPEAT_DELAY - 1)) begin
                rep_d   = 1'b1;
                hold_d  = 1'b1;
                hcnt_d  = '0;
                state_d = ST_REPEAT;
              end else begin
                hcnt_d = hcnt_q + HW'(1);
              end
            end
            ST_REPEAT: begin
              if (hcnt_q == HW'(REPEAT_PERIOD - 1)) begin
                rep_d  = 1'b1;
                hcnt_d = '0;
              end else begin
                hcnt_d = hcnt_q + HW'(1);
              end
            end
            default: begin
              hcnt_d = '0;
              hold_d = 1'b0;
            end
          endcase
        end
      end

      assign o_hold[ch]   = hold_q;
      assign o_repeat[ch] = rep_q;
    end else begin : g_norep
      assign o_hold[ch]   = 1'b0;
      assign o_repeat[ch] = 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//   Directed bench for btn_conditioner with small timing parameters.
//   Expected output values are queued (tagged with the clock edge after which
//   they must hold) as stimulus is planned; a negedge checker pops and
//   compares each entry when the DUT reaches that edge.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  localparam int N_CH = 5;

  localparam int SEL_LEVEL   = 0;
  localparam int SEL_PRESS   = 1;
  localparam int SEL_RELEASE = 2;
  localparam int SEL_HOLD    = 3;
  localparam int SEL_REPEAT  = 4;

  typedef struct {
    int              edge_n;
    int              sel;
    logic [N_CH-1:0] mask;
    logic [N_CH-1:0] value;
    string           tag;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] level, press, release_p, hold, rep;

  exp_t sb[$];
  int   edges  = 0;
  int   errors = 0;
  int   checks = 0;
  int   t;

  btn_conditioner #(
    .N_CH            (N_CH),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3),
    .REPEAT_MASK     (5'b01111)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_raw     (raw),
    .o_level   (level),
    .o_press   (press),
    .o_release (release_p),
    .o_hold    (hold),
    .o_repeat  (rep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Queue one expectation: (output & mask) must equal value after edge e.
  task automatic expect_at(input int e, input int sel, input logic [N_CH-1:0] mask,
                           input logic [N_CH-1:0] value, input string tag);
    exp_t x;
    x.edge_n = e;
    x.sel    = sel;
    x.mask   = mask;
    x.value  = value;
    x.tag    = tag;
    sb.push_back(x);
  endtask

  task automatic expect_all_zero(input int e, input string tag);
    for (int s = SEL_LEVEL; s <= SEL_REPEAT; s++) expect_at(e, s, '1, '0, tag);
  endtask

  task automatic goto_edge(input int e);
    while (edges < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard checker: away from the active edge, compare everything due now.
  always @(negedge clk) begin
    logic [N_CH-1:0] obs;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].edge_n <= edges) begin
        case (sb[i].sel)
          SEL_LEVEL:   obs = level;
          SEL_PRESS:   obs = press;
          SEL_RELEASE: obs = release_p;
          SEL_HOLD:    obs = hold;
          default:     obs = rep;
        endcase
        checks++;
        assert (sb[i].edge_n == edges && (obs & sb[i].mask) === sb[i].value) else begin
          errors++;
          $error("FAIL %s edge=%0d due=%0d observed=%b expected=%b mask=%b",
                 sb[i].tag, edges, sb[i].edge_n, obs & sb[i].mask, sb[i].value, sb[i].mask);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    rst = 1'b1;
    raw = 5'h1F;

    // 1. Reset held with all inputs high: everything stays 0.
    for (int e = 1; e <= 3; e++) expect_all_zero(e, "reset_held");
    goto_edge(3);
    rst = 1'b0;
    raw = '0;
    expect_all_zero(10, "idle_after_reset");
    goto_edge(11);

    t = edges;
    // 2. Channels 0 and 2 rise together: level/press after 6 edges, 1 cycle wide.
    expect_at(t + 5, SEL_LEVEL, 5'b00101, 5'b00000, "lvl_before_latency");
    expect_at(t + 5, SEL_PRESS, 5'b00101, 5'b00000, "press_before_latency");
    expect_at(t + 6, SEL_LEVEL, 5'b11111, 5'b00101, "lvl_ch0_ch2");
    expect_at(t + 6, SEL_PRESS, 5'b11111, 5'b00101, "press_ch0_ch2");
    expect_at(t + 7, SEL_PRESS, 5'b11111, 5'b00000, "press_width");
    // Channel 2 released just before its first repeat would have fired.
    expect_at(t + 13, SEL_RELEASE, 5'b00100, 5'b00000, "rel_ch2_early");
    expect_at(t + 14, SEL_RELEASE, 5'b00100, 5'b00100, "rel_ch2");
    expect_at(t + 14, SEL_LEVEL,   5'b00100, 5'b00000, "lvl_ch2_low");
    // 3. Channel 1 glitch of 3 cycles is ignored.
    for (int e = t + 10; e <= t + 20; e++) begin
      expect_at(e, SEL_LEVEL,   5'b00010, 5'b00000, "glitch_lvl_ch1");
      expect_at(e, SEL_PRESS,   5'b00010, 5'b00000, "glitch_press_ch1");
      expect_at(e, SEL_RELEASE, 5'b00010, 5'b00000, "glitch_rel_ch1");
    end
    // 4. Channel 0 held: repeats at press+10, +13, +16, +19, +22.
    expect_at(t + 15, SEL_HOLD, 5'b00111, 5'b00000, "hold_before_delay");
    for (int e = t + 15; e <= t + 30; e++)
      expect_at(e, SEL_REPEAT, 5'b00111,
                ((e - t - 16) >= 0 && (e - t - 16) % 3 == 0) ? 5'b00001 : 5'b00000,
                "repeat_ch0");
    expect_at(t + 16, SEL_HOLD, 5'b00111, 5'b00001, "hold_rise");
    expect_at(t + 30, SEL_HOLD, 5'b00001, 5'b00001, "hold_before_release");
    // Release lands on the edge of a would-be repeat: release wins.
    expect_at(t + 30, SEL_RELEASE, 5'b00001, 5'b00000, "rel_ch0_early");
    expect_at(t + 31, SEL_RELEASE, 5'b00001, 5'b00001, "rel_ch0");
    expect_at(t + 31, SEL_LEVEL,   5'b00001, 5'b00000, "lvl_ch0_low");
    expect_at(t + 31, SEL_HOLD,    5'b00001, 5'b00000, "hold_drop");
    for (int e = t + 31; e <= t + 36; e++)
      expect_at(e, SEL_REPEAT, 5'b00001, 5'b00000, "no_repeat_after_release");
    expect_at(t + 32, SEL_RELEASE, 5'b00001, 5'b00000, "rel_width");
    // 5. Masked channel 4 held for 40 cycles: press/release, never hold/repeat.
    expect_at(t + 46, SEL_PRESS, 5'b10000, 5'b10000, "press_ch4");
    expect_at(t + 46, SEL_LEVEL, 5'b10000, 5'b10000, "lvl_ch4");
    for (int e = t + 50; e <= t + 85; e += 3) begin
      expect_at(e, SEL_HOLD,   5'b10000, 5'b00000, "masked_hold_ch4");
      expect_at(e, SEL_REPEAT, 5'b10000, 5'b00000, "masked_repeat_ch4");
    end
    expect_at(t + 86, SEL_RELEASE, 5'b10000, 5'b10000, "rel_ch4");
    expect_at(t + 86, SEL_LEVEL,   5'b10000, 5'b00000, "lvl_ch4_low");
    // 6. Reset at press+12 while channel 0 is still held.
    expect_at(t + 96,  SEL_PRESS,  5'b11111, 5'b00001, "press2_ch0");
    expect_at(t + 106, SEL_REPEAT, 5'b11111, 5'b00001, "repeat2_ch0");
    expect_at(t + 107, SEL_HOLD,   5'b11111, 5'b00001, "hold2_ch0");
    expect_all_zero(t + 108, "reset_while_pressed");
    expect_at(t + 113, SEL_PRESS, 5'b11111, 5'b00000, "repress_early");
    expect_at(t + 113, SEL_LEVEL, 5'b11111, 5'b00000, "relevel_early");
    expect_at(t + 114, SEL_PRESS, 5'b11111, 5'b00001, "repress_ch0");
    expect_at(t + 114, SEL_LEVEL, 5'b11111, 5'b00001, "relevel_ch0");

    raw = 5'b00101;
    goto_edge(t + 8);
    raw[2] = 1'b0;
    goto_edge(t + 9);
    raw[1] = 1'b1;
    goto_edge(t + 12);
    raw[1] = 1'b0;
    goto_edge(t + 25);
    raw[0] = 1'b0;
    goto_edge(t + 40);
    raw[4] = 1'b1;
    goto_edge(t + 80);
    raw[4] = 1'b0;
    goto_edge(t + 90);
    raw[0] = 1'b1;
    goto_edge(t + 107);
    rst = 1'b1;
    goto_edge(t + 108);
    rst = 1'b0;
    goto_edge(t + 120);
    raw[0] = 1'b0;
    goto_edge(t + 130);
    @(posedge clk);
    #1;

    // Every queued expectation must have been consumed by the checker.
    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0 pending entries", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
